// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   Memory address / data register pair with a handshake FSM for
//   variable-latency memory. Replaces the fixed 16-bit MAR/MDR pair on the
//   processor data bus. Supports word and byte accesses, lane selection,
//   alignment checking and a response timeout.
//
// Ports
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   bus_in       : processor data bus value
//   load_mar     : MAR <= bus_in (zero-extended / truncated to ADDR_WIDTH)
//   load_mdr     : MDR <= bus_in
//   start_read   : begin a read at MAR
//   start_write  : begin a write of MDR to MAR
//   byte_mode    : sampled with a start; 1 = byte access
//   mar_out      : MAR contents
//   mdr_out      : MDR contents (drives the bus through the tri-state gate)
//   busy         : FSM not idle
//   done         : one-cycle completion pulse
//   err          : sticky error, cleared by the next accepted start
//   mem_addr     : memory address (equals MAR)
//   mem_wdata    : memory write data
//   mem_byte_en  : memory lane enables
//   mem_read     : read request, held until response
//   mem_write    : write request, held until response
//   mem_rdata    : memory read data, valid with mem_resp
//   mem_resp     : memory response
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        bus_in,
  input  logic                    load_mar,
  input  logic                    load_mdr,
  input  logic                    start_read,
  input  logic                    start_write,
  input  logic                    byte_mode,
  output logic [ADDR_WIDTH-1:0]   mar_out,
  output logic [WIDTH-1:0]        mdr_out,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [WIDTH-1:0]        mem_wdata,
  output logic [WIDTH/8-1:0]      mem_byte_en,
  output logic                    mem_read,
  output logic                    mem_write,
  input  logic [WIDTH-1:0]        mem_rdata,
  input  logic                    mem_resp
);

  localparam int NLANES = WIDTH / 8;
  localparam int LB     = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam int CW     = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   mar_r;
  logic [WIDTH-1:0]        mdr_r;
  logic [CW-1:0]           cnt_r;
  logic [LB-1:0]           lane_r;
  logic                    byte_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    err_r;
  logic                    mem_read_r;
  logic                    mem_write_r;
  logic [NLANES-1:0]       mem_be_r;
  logic [WIDTH-1:0]        mem_wdata_r;

  logic [LB-1:0]           start_lane_s;
  logic [7:0]              rd_byte_s;
  logic [WIDTH-1:0]        rd_sext_s;

  // Lane enables: one-hot at the lane for byte accesses, all lanes for words.
  function automatic logic [NLANES-1:0] lane_mask(input logic bm, input logic [LB-1:0] ln);
    logic [NLANES-1:0] m;
    m = '0;
    for (int i = 0; i < NLANES; i++) begin
      m[i] = bm ? (ln == LB'(i)) : 1'b1;
    end
    return m;
  endfunction

  // Extract the byte at the given lane of a data word.
  function automatic logic [7:0] get_byte(input logic [WIDTH-1:0] d, input logic [LB-1:0] ln);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < NLANES; i++) begin
      if (ln == LB'(i)) begin
        b = d[i*8 +: 8];
      end else begin
        b = b;
      end
    end
    return b;
  endfunction

  // Lane of the current MAR and the sign-extended read byte at the latched lane.
  always_comb begin
    start_lane_s = mar_r[LB-1:0];
    rd_byte_s    = get_byte(mem_rdata, lane_r);
    rd_sext_s    = {{(WIDTH-8){rd_byte_s[7]}}, rd_byte_s};
  end

  // Access FSM together with the MAR/MDR registers and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      mar_r       <= '0;
      mdr_r       <= '0;
      cnt_r       <= '0;
      lane_r      <= '0;
      byte_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      mem_be_r    <= '0;
      mem_wdata_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (load_mar) begin
            mar_r <= ADDR_WIDTH'(bus_in);
          end
          if (load_mdr) begin
            mdr_r <= bus_in;
          end
          // The start sees the pre-edge MAR even if load_mar is also high.
          if (start_read || start_write) begin
            err_r  <= 1'b0;
            byte_r <= byte_mode;
            lane_r <= start_lane_s;
            if (start_read && start_write) begin
              err_r  <= 1'b1;
              done_r <= 1'b1;
            end else if (!byte_mode && (start_lane_s != '0)) begin
              // Misaligned word: report immediately, no memory request.
              err_r  <= 1'b1;
              done_r <= 1'b1;
            end else begin
              busy_r   <= 1'b1;
              cnt_r    <= '0;
              mem_be_r <= lane_mask(byte_mode, start_lane_s);
              if (start_read) begin
                state_r    <= ST_READ;
                mem_read_r <= 1'b1;
              end else begin
                state_r     <= ST_WRITE;
                mem_write_r <= 1'b1;
                mem_wdata_r <= byte_mode ? {NLANES{mdr_r[7:0]}} : mdr_r;
              end
            end
          end
        end
        ST_READ, ST_WRITE: begin
          // A response on the timeout edge still counts as success.
          if (mem_resp) begin
            state_r     <= ST_FINISH;
            done_r      <= 1'b1;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            mem_be_r    <= '0;
            if (state_r == ST_READ) begin
              mdr_r <= byte_r ? rd_sext_s : mem_rdata;
            end
          end else if (cnt_r == CW'(TIMEOUT - 1)) begin
            state_r     <= ST_FINISH;
            done_r      <= 1'b1;
            err_r       <= 1'b1;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            mem_be_r    <= '0;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_FINISH: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          mem_read_r  <= 1'b0;
          mem_write_r <= 1'b0;
          mem_be_r    <= '0;
        end
      endcase
    end
  end

  assign mar_out     = mar_r;
  assign mdr_out     = mdr_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign err         = err_r;
  assign mem_addr    = mar_r;
  assign mem_wdata   = mem_wdata_r;
  assign mem_byte_en = mem_be_r;
  assign mem_read    = mem_read_r;
  assign mem_write   = mem_write_r;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised successor to the fixed 16-bit MAR/MDR pair on the processor data bus.
- Owns the MAR and MDR registers and runs a handshake FSM for variable-latency memory.
- Supports word and byte (LDB/STB-style) accesses, lane selection, alignment checking and a response timeout.
- Sits between the bus tri-state gating (mdr_out drives the bus via the gate) and the external memory.

Parameters:
WIDTH, 16, data word width in bits; multiple of 8, >= 16
ADDR_WIDTH, 16, byte address width
NLANES, WIDTH/8, byte lanes (derived, not overridable); LB = log2(NLANES)
TIMEOUT, 15, max cycles waiting for mem_resp before error; >= 1

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
bus_in  in  WIDTH  data bus value
load_mar  in  1  MAR <= bus_in[ADDR_WIDTH-1:0] (zero-extend if ADDR_WIDTH > WIDTH)
load_mdr  in  1  MDR <= bus_in
start_read  in  1  begin read at MAR
start_write  in  1  begin write of MDR to MAR
byte_mode  in  1  sampled with start; 1 = byte access
mar_out  out  ADDR_WIDTH  MAR contents
mdr_out  out  WIDTH  MDR contents
busy  out  1  FSM not IDLE
done  out  1  one-cycle completion pulse
err  out  1  sticky error; cleared by next accepted start
mem_addr  out  ADDR_WIDTH  equals MAR
mem_wdata  out  WIDTH  write data
mem_byte_en  out  NLANES  lane enables
mem_read  out  1  read request, held until response
mem_write  out  1  write request, held until response
mem_rdata  in  WIDTH  read data, valid with mem_resp
mem_resp  in  1  memory response

Behaviour:
- Reset low, asynchronous:
  - MAR, MDR = 0; state = IDLE; timeout counter = 0.
  - busy, done, err, mem_read, mem_write = 0; mem_byte_en = 0.
- State machine:
  - States IDLE, READ, WRITE, FINISH. All outputs registered.
- IDLE:
  - load_mar and load_mdr act on the next edge; both may assert together.
  - Start handling (start_read or start_write):
    - Sample byte_mode; clear err.
    - lane = MAR[LB-1:0].
    - Word access with lane != 0: err = 1, done pulses the next cycle, no memory request, stay IDLE.
    - start_read and start_write in the same cycle: err = 1, done pulse, no access.
    - Otherwise start_read goes to READ and start_write goes to WRITE.
  - A load_mar in the same cycle as a start: the start uses the old MAR value, and MAR updates at that edge.
- READ / WRITE:
  - mem_read or mem_write is high from the first cycle in the state until the cycle after mem_resp is sampled.
  - Byte write:
    - mem_wdata = MDR[7:0] replicated to all lanes.
    - mem_byte_en = one-hot at lane.
  - Word write: mem_wdata = MDR; mem_byte_en all ones.
  - Read: mem_byte_en is the same lane mask.
  - load_mar, load_mdr and starts are ignored while busy.
- Response:
  - On the edge where mem_resp = 1, go to FINISH and drop the request.
  - Read, word mode: MDR <= mem_rdata.
  - Read, byte mode: MDR <= sign-extended mem_rdata byte at lane.
  - Write: MDR is unchanged.
- FINISH: done = 1 for exactly one cycle, then IDLE. busy stays high in FINISH.
- Latency: start at edge t, request visible after t, mem_resp at edge k, done high during cycle k+1, new start accepted at edge k+2.
  - Minimum read turnaround is 3 cycles with zero-wait memory (mem_resp high in the first request cycle).
- Timeout:
  - Counter clears on entry to READ/WRITE and increments each cycle without mem_resp.
  - When it reaches TIMEOUT: drop request, err = 1, go to FINISH. MDR is unchanged.
  - mem_resp on the same edge as the counter hitting TIMEOUT counts as success.
- mem_resp in IDLE or FINISH is ignored.
- Reset asserted mid-access: immediate return to reset values; the request drops asynchronously.

Test Plan:
- Word read, 2 wait states:
  - Stimulus: load_mar bus_in = 0x3000; start_read; mem_resp on 3rd request cycle with 0xBEEF.
  - Required: mem_read high 3 cycles, MDR = 0xBEEF, done one cycle, err = 0.
- Byte read, odd address:
  - Stimulus: MAR = 0x3001; byte_mode = 1; mem_rdata = 0x80FF.
  - Required: mem_byte_en = 2'b10, MDR = 0xFF80.
- Byte write, even address:
  - Stimulus: MDR = 0x1234; MAR = 0x4000; byte_mode = 1; start_write; zero-wait.
  - Required: mem_wdata = 0x3434, mem_byte_en = 2'b01, MDR still 0x1234.
- Unaligned word write at 0x4001 -> err = 1, done pulse, mem_write never asserted.
- No mem_resp, TIMEOUT = 15:
  - Required: mem_read high exactly 15 cycles, then err = 1, done pulse, MDR unchanged.
  - Next valid start clears err.
- Reset during READ:
  - Stimulus: Reset low asynchronously in the 2nd wait cycle.
  - Required: mem_read, busy, MAR, MDR all 0 immediately; after release, start_read proceeds normally.
  - Also run WIDTH = 32: byte read at lane 3 selects bits [31:24].
